// File: rtl/nmr_sample_writer.sv
// NMR sample writer: packs ADC sample pairs two-per-64-bit word and writes
// them into a circular BRAM buffer during an acquisition window, then
// flushes any half-filled word and reports completion to the sequencer.
module nmr_sample_writer #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              rst_writer,
  input  logic              en_acq,
  input  logic [31:0]       size,
  input  logic [31:0]       nb_of_sample,
  input  logic [15:0]       adc_dat_a,
  input  logic [15:0]       adc_dat_b,
  input  logic              adc_valid,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [63:0]       bram_wdata,
  output logic              bram_we,
  output logic [31:0]       sts,
  output logic              done,
  output logic              wrapped,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_CAPTURE = 3'd2,
    S_FLUSH   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic [ADDR_W-1:0]  r_size;
  logic [31:0]        r_nb;
  logic [ADDR_W-1:0]  r_addr;
  logic [ADDR_W-1:0]  r_bram_addr;
  logic [63:0]        r_wdata;
  logic               r_we;
  logic [31:0]        r_count;
  logic               r_wrapped;
  logic [31:0]        r_pack;
  logic               r_half;

  logic               w_accept;
  logic               w_write;
  logic [63:0]        w_wdata;
  logic [31:0]        w_count_next;
  logic [ADDR_W-1:0]  w_last_addr;
  logic               w_unused_size;

  // Only the low ADDR_W bits of size select the buffer depth.
  assign w_unused_size = ^size;

  // Size of zero in the low bits wraps naturally to an all-ones last address,
  // giving the full 2^ADDR_W depth.
  assign w_last_addr  = r_size - ADDR_W'(1);
  assign w_count_next = (w_accept && (r_count != 32'hFFFF_FFFF)) ? (r_count + 32'd1) : r_count;

  // State register.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; the soft clear overrides every transition.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (en_acq) w_state_next = S_ARM;
      S_ARM:     w_state_next = (nb_of_sample == 32'd0) ? S_DONE : S_CAPTURE;
      S_CAPTURE: if ((w_count_next == r_nb) || !en_acq) w_state_next = S_FLUSH;
      S_FLUSH:   w_state_next = S_DONE;
      S_DONE:    if (!en_acq) w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
    if (rst_writer) w_state_next = S_IDLE;
  end

  // Per-state outputs and datapath controls.
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    w_accept = 1'b0;
    w_write  = 1'b0;
    w_wdata  = 64'd0;
    case (r_state)
      S_ARM: begin
        busy = 1'b1;
      end
      S_CAPTURE: begin
        busy     = 1'b1;
        w_accept = adc_valid;
        w_write  = adc_valid & r_half;
        w_wdata  = {adc_dat_b, adc_dat_a, r_pack};
      end
      S_FLUSH: begin
        busy    = 1'b1;
        w_write = r_half;
        w_wdata = {32'd0, r_pack};
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Datapath: configuration latch, pair packing, address walk and counters.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_size      <= '0;
      r_nb        <= '0;
      r_addr      <= '0;
      r_bram_addr <= '0;
      r_wdata     <= '0;
      r_we        <= 1'b0;
      r_count     <= '0;
      r_wrapped   <= 1'b0;
      r_pack      <= '0;
      r_half      <= 1'b0;
    end else if (rst_writer) begin
      r_size      <= '0;
      r_nb        <= '0;
      r_addr      <= '0;
      r_bram_addr <= '0;
      r_wdata     <= '0;
      r_we        <= 1'b0;
      r_count     <= '0;
      r_wrapped   <= 1'b0;
      r_pack      <= '0;
      r_half      <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (r_state == S_ARM) begin
        r_size    <= size[ADDR_W-1:0];
        r_nb      <= nb_of_sample;
        r_addr    <= '0;
        r_count   <= '0;
        r_wrapped <= 1'b0;
        r_pack    <= '0;
        r_half    <= 1'b0;
      end
      if (w_accept) begin
        r_count <= w_count_next;
        if (!r_half) begin
          r_pack <= {adc_dat_b, adc_dat_a};
          r_half <= 1'b1;
        end
      end
      // Write strobe lands the cycle after the completing pair (or flush);
      // the address register advances so the next word is already lined up.
      if (w_write) begin
        r_we        <= 1'b1;
        r_wdata     <= w_wdata;
        r_bram_addr <= r_addr;
        r_half      <= 1'b0;
        if (r_addr == w_last_addr) begin
          r_addr    <= '0;
          r_wrapped <= 1'b1;
        end else begin
          r_addr <= r_addr + ADDR_W'(1);
        end
      end
    end
  end

  assign bram_addr  = r_bram_addr;
  assign bram_wdata = r_wdata;
  // A pending strobe is suppressed in the very cycle the soft clear arrives.
  assign bram_we    = r_we & ~rst_writer;
  assign sts        = r_count;
  assign wrapped    = r_wrapped;

endmodule

// File: tb/tb_nmr_sample_writer.sv
// Directed bench for nmr_sample_writer with a write scoreboard.
module tb_nmr_sample_writer;

  localparam int AW = 16;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [63:0]   data;
  } wr_t;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic          rst_writer = 1'b0;
  logic          en_acq = 1'b0;
  logic [31:0]   size = 32'd0;
  logic [31:0]   nb_of_sample = 32'd0;
  logic [15:0]   adc_dat_a = 16'd0;
  logic [15:0]   adc_dat_b = 16'd0;
  logic          adc_valid = 1'b0;
  logic [AW-1:0] bram_addr;
  logic [63:0]   bram_wdata;
  logic          bram_we;
  logic [31:0]   sts;
  logic          done;
  logic          wrapped;
  logic          busy;

  int  checks = 0;
  int  failures = 0;
  wr_t exp_q[$];
  wr_t mon_e;

  // reference model state for expected writes
  int          m_addr;
  int          m_size;
  logic        m_half;
  logic [31:0] m_pack;

  always #5 clk = ~clk;

  nmr_sample_writer #(.ADDR_W(AW)) dut (
    .clk          (clk),
    .aresetn      (aresetn),
    .rst_writer   (rst_writer),
    .en_acq       (en_acq),
    .size         (size),
    .nb_of_sample (nb_of_sample),
    .adc_dat_a    (adc_dat_a),
    .adc_dat_b    (adc_dat_b),
    .adc_valid    (adc_valid),
    .bram_addr    (bram_addr),
    .bram_wdata   (bram_wdata),
    .bram_we      (bram_we),
    .sts          (sts),
    .done         (done),
    .wrapped      (wrapped),
    .busy         (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // write monitor: every strobe must match the oldest expected write
  always @(negedge clk) begin
    if (bram_we === 1'b1) begin
      $display("write addr=0x%0h data=0x%016h", bram_addr, bram_wdata);
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_write observed addr=0x%0h data=0x%0h expected=no write", bram_addr, bram_wdata);
      end
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 64'(bram_addr), 64'(mon_e.addr));
        chk("wr_data", bram_wdata, mon_e.data);
      end
    end
  end

  task automatic push_exp(input int addr, input logic [63:0] data);
    wr_t e;
    e.addr = AW'(addr);
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic model_advance();
    m_addr = (m_addr == m_size - 1) ? 0 : m_addr + 1;
  endtask

  task automatic drive_pair(input logic [15:0] a, input logic [15:0] b);
    adc_dat_a = a;
    adc_dat_b = b;
    adc_valid = 1'b1;
    step();
    adc_valid = 1'b0;
  endtask

  task automatic model_pair(input logic [15:0] a, input logic [15:0] b);
    if (m_half) begin
      push_exp(m_addr, {b, a, m_pack});
      model_advance();
      m_half = 1'b0;
    end else begin
      m_pack = {b, a};
      m_half = 1'b1;
    end
    drive_pair(a, b);
  endtask

  task automatic model_flush();
    if (m_half) begin
      push_exp(m_addr, {32'd0, m_pack});
      model_advance();
      m_half = 1'b0;
    end
  endtask

  task automatic start_acq(input int sz, input int nb);
    m_addr = 0;
    m_size = sz;
    m_half = 1'b0;
    m_pack = 32'd0;
    size = 32'(sz);
    nb_of_sample = 32'(nb);
    en_acq = 1'b1;
    step();
    chk("busy_arm", 64'(busy), 64'd1);
    step();
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (done !== 1'b1 && n < limit) begin
      step();
      n++;
    end
    checks++;
    assert (done === 1'b1) else begin
      failures++;
      $error("FAIL done_timeout observed done=%b expected=1 within %0d cycles", done, limit);
    end
  endtask

  task automatic finish_acq(input string tag, input int exp_sts, input logic exp_wrapped);
    wait_done(50);
    step();
    chk({tag, "_sts"}, 64'(sts), 64'(exp_sts));
    chk({tag, "_wrapped"}, 64'(wrapped), 64'(exp_wrapped));
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
    en_acq = 1'b0;
    step();
    step();
    chk({tag, "_idle"}, 64'(done), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    step();
    step();
    chk("rst_addr", 64'(bram_addr), 64'd0);
    chk("rst_wdata", bram_wdata, 64'd0);
    chk("rst_we", 64'(bram_we), 64'd0);
    chk("rst_sts", 64'(sts), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_wrapped", 64'(wrapped), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    aresetn = 1'b1;
    step();

    // four consecutive pairs, two full words
    start_acq(16, 4);
    push_exp(0, 64'h0101_0002_0100_0001);
    push_exp(1, 64'h0103_0004_0102_0003);
    for (int i = 0; i < 4; i++) drive_pair(16'(i + 1), 16'(16'h0100 + i));
    finish_acq("four", 4, 1'b0);

    // odd count, last word flushed with zero upper half
    start_acq(16, 3);
    push_exp(0, 64'h0201_0002_0200_0001);
    push_exp(1, 64'h0000_0000_0202_0003);
    for (int i = 0; i < 3; i++) drive_pair(16'(i + 1), 16'(16'h0200 + i));
    finish_acq("three", 3, 1'b0);

    // wrap in a two-word buffer, pairs with gaps
    start_acq(2, 10);
    for (int i = 0; i < 10; i++) begin
      model_pair(16'(16'h0010 + i), 16'(16'h0300 + i));
      if (i % 2 == 1) step();
    end
    finish_acq("wrap", 10, 1'b1);

    // zero samples: straight to DONE, valid ignored, no writes
    size = 32'd16;
    nb_of_sample = 32'd0;
    en_acq = 1'b1;
    adc_valid = 1'b1;
    step();
    step();
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_sts", 64'(sts), 64'd0);
    chk("zero_wrapped", 64'(wrapped), 64'd0);
    chk("zero_busy", 64'(busy), 64'd0);
    step();
    chk("zero_hold_done", 64'(done), 64'd1);
    adc_valid = 1'b0;
    en_acq = 1'b0;
    step();
    step();
    chk("zero_idle", 64'(done), 64'd0);

    // acquisition window closed early after five pairs
    start_acq(16, 1024);
    for (int i = 0; i < 5; i++) model_pair(16'(16'h0040 + i), 16'(16'h0500 + i));
    en_acq = 1'b0;
    model_flush();
    wait_done(20);
    chk("early_sts", 64'(sts), 64'd5);
    step();
    step();
    chk("early_idle", 64'(done), 64'd0);
    chk("early_pending", 64'(exp_q.size()), 64'd0);

    // soft clear mid-capture after three pairs, then a fresh start
    start_acq(16, 100);
    for (int i = 0; i < 3; i++) model_pair(16'(16'h0060 + i), 16'(16'h0600 + i));
    rst_writer = 1'b1;
    en_acq = 1'b0;
    step();
    rst_writer = 1'b0;
    chk("clr_sts", 64'(sts), 64'd0);
    chk("clr_busy", 64'(busy), 64'd0);
    chk("clr_done", 64'(done), 64'd0);
    chk("clr_addr", 64'(bram_addr), 64'd0);
    chk("clr_wdata", bram_wdata, 64'd0);
    for (int i = 0; i < 3; i++) drive_pair(16'hAAAA, 16'hBBBB);
    chk("clr_idle_sts", 64'(sts), 64'd0);
    chk("clr_pending", 64'(exp_q.size()), 64'd0);
    start_acq(16, 2);
    model_pair(16'h0071, 16'h0701);
    model_pair(16'h0072, 16'h0702);
    finish_acq("restart", 2, 1'b0);

    // soft clear in the cycle a word write is due: strobe suppressed
    start_acq(16, 100);
    drive_pair(16'h0081, 16'h0801);
    drive_pair(16'h0082, 16'h0802);
    rst_writer = 1'b1;
    en_acq = 1'b0;
    step();
    rst_writer = 1'b0;
    step();
    chk("supp_sts", 64'(sts), 64'd0);
    chk("supp_we", 64'(bram_we), 64'd0);

    // asynchronous reset mid-capture takes effect without a clock edge
    start_acq(16, 100);
    model_pair(16'h0091, 16'h0901);
    model_pair(16'h0092, 16'h0902);
    drive_pair(16'h0093, 16'h0903);
    chk("pre_arst_sts", 64'(sts), 64'd3);
    aresetn = 1'b0;
    #2;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_sts", 64'(sts), 64'd0);
    chk("arst_we", 64'(bram_we), 64'd0);
    chk("arst_addr", 64'(bram_addr), 64'd0);
    chk("arst_wdata", bram_wdata, 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_pending", 64'(exp_q.size()), 64'd0);
    en_acq = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
